// File: rtl/dense_dot_calc.sv
// Dot-product engine: multiply-accumulates two N-element Q(FRAC) vectors LANES per cycle,
// adds a bias, rescales, saturates, optionally applies ReLU and returns one result via valid/ready.
module dense_dot_calc #(
  parameter int WIDTH   = 16,
  parameter int N       = 25,
  parameter int LANES   = 5,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int RELU_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH*(2*N+1)-1:0]   data_from_layer_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [WIDTH-1:0]           data_to_layer_o,
  output logic                       sat_o,
  output logic                       busy_o
);

  localparam int NG    = N / LANES;
  localparam int GRP_W = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW    = WIDTH * (2 * N + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (WIDTH - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FIN,
    S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             pkt_q, pkt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [GRP_W-1:0]          grp_q, grp_d;
  logic [WIDTH-1:0]          res_q, res_d;
  logic                      sat_q, sat_d;
  logic                      valid_q, valid_d;

  logic signed [ACC_W-1:0]   mac_sum;
  logic signed [WIDTH-1:0]   bias_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   shr_s;
  logic [WIDTH-1:0]          fin_res;
  logic                      fin_sat;

  // Sum of the LANES products for the current group, each sign-extended to ACC_W.
  always_comb begin
    mac_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      int unsigned             idx;
      logic signed [WIDTH-1:0]   a;
      logic signed [WIDTH-1:0]   b;
      logic signed [2*WIDTH-1:0] p;
      idx     = 32'(grp_q) * 32'(LANES) + l;
      a       = pkt_q[WIDTH*(N+1) + WIDTH*idx +: WIDTH];
      b       = pkt_q[WIDTH + WIDTH*idx +: WIDTH];
      p       = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      mac_sum = mac_sum + ACC_W'(p);
    end
  end

  // Bias is aligned to the product scale, then the sum is shifted back to Q(FRAC).
  always_comb begin
    bias_s  = pkt_q[WIDTH-1:0];
    sum_s   = acc_q + (ACC_W'(bias_s) <<< FRAC);
    shr_s   = sum_s >>> FRAC;
    fin_sat = 1'b0;
    fin_res = shr_s[WIDTH-1:0];
    if (shr_s > SAT_MAX) begin
      fin_res = {1'b0, {(WIDTH-1){1'b1}}};
      fin_sat = 1'b1;
    end else if (shr_s < SAT_MIN) begin
      fin_res = {1'b1, {(WIDTH-1){1'b0}}};
      fin_sat = 1'b1;
    end
    if ((RELU_EN != 0) && fin_res[WIDTH-1]) begin
      fin_res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    res_d   = res_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          pkt_d   = data_from_layer_i;
          acc_d   = '0;
          grp_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + mac_sum;
        grp_d = grp_q + GRP_W'(1);
        if (grp_q == GRP_W'(NG - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        res_d   = fin_res;
        sat_d   = fin_sat;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      acc_q   <= '0;
      grp_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o      = (state_q == S_IDLE) && !rst;
  assign busy_o          = (state_q != S_IDLE);
  assign result_valid_o  = valid_q;
  assign data_to_layer_o = res_q;
  assign sat_o           = sat_q;

endmodule
